// File: rtl/prog_bitstream_loader.sv
// Bitstream loader for the fabric prog bus. Takes SYNC_WORD-framed 32-bit words from a valid/ready
// stream, shifts the payload MSB-first into prog and validates the frame against a trailing XOR checksum.
module prog_bitstream_loader #(
    parameter int                PROG_W    = 4416,
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] SYNC_WORD = 32'hAA995566,
    parameter int                NWORDS    = PROG_W / WORD_W
) (
    input  logic              clb_clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              abort,
    output logic [PROG_W-1:0] prog,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy,
    output logic [7:0]        word_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    localparam logic [7:0] LAST_CNT = 8'(NWORDS - 1);
    localparam logic [7:0] FULL_CNT = 8'(NWORDS);

    state_t              r_state;
    logic [PROG_W-1:0]   r_prog;
    logic [WORD_W-1:0]   r_chk;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_cnt;
    logic                w_xfer;

    assign s_ready  = (r_state != COMMIT);
    assign busy     = (r_state == LOAD) || (r_state == CHECK);
    assign w_xfer   = s_valid && s_ready;
    assign prog     = r_prog;
    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign word_cnt = r_cnt;

    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prog  <= '0;
            r_chk   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer && (s_data == SYNC_WORD)) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                        r_chk   <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    // abort wins over a same-cycle transfer; the word is dropped
                    if (abort) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_xfer) begin
                        r_prog <= {r_prog[PROG_W-WORD_W-1:0], s_data};
                        r_chk  <= r_chk ^ s_data;
                        if (r_cnt != FULL_CNT)
                            r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LAST_CNT)
                            r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_xfer) begin
                        r_done  <= (s_data == r_chk);
                        r_err   <= (s_data != r_chk);
                        r_state <= COMMIT;
                    end
                end
                COMMIT: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_bitstream_loader.sv
// Self-checking bench for prog_bitstream_loader: scenario table plus randomized frames checked
// against a model where prog is simply the most recent NWORDS accepted payload words.
module tb_prog_bitstream_loader;

    localparam int          PROG_W = 4416;
    localparam int          WORD_W = 32;
    localparam int          NW     = PROG_W / WORD_W;
    localparam logic [31:0] SYNC   = 32'hAA995566;

    logic              clb_clk = 1'b0;
    logic              rst;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              abort;
    logic [PROG_W-1:0] prog;
    logic              cfg_done;
    logic              cfg_err;
    logic              busy;
    logic [7:0]        word_cnt;

    prog_bitstream_loader #(.PROG_W(PROG_W), .WORD_W(WORD_W), .SYNC_WORD(SYNC)) dut (
        .clb_clk (clb_clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .abort   (abort),
        .prog    (prog),
        .cfg_done(cfg_done),
        .cfg_err (cfg_err),
        .busy    (busy),
        .word_cnt(word_cnt)
    );

    always #5 clb_clk = ~clb_clk;

    typedef struct {
        int pat;       // 0: word i = i, 1: random, 2: word i = i but word 5 = SYNC
        bit flip;      // corrupt checksum bit0
        int gap_pct;   // chance of idle cycles before each word
        int abort_at;  // word index at which abort is raised (-1 none, NW = during CHECK)
        bit junk;      // junk words in IDLE first
        bit exp_done;
        bit exp_err;
        int exp_cnt;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] hist[$];
    bit          m_done;
    bit          m_err;
    int          m_cnt;

    function automatic logic [PROG_W-1:0] model_prog();
        logic [PROG_W-1:0] p;
        int n;
        p = '0;
        n = hist.size();
        for (int i = 0; i < NW; i++)
            p[PROG_W-1-WORD_W*i -: WORD_W] = hist[n-NW+i];
        return p;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NW; i++) hist.push_back(32'h0);
        m_done = 0;
        m_err  = 0;
        m_cnt  = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_prog(input string name);
        logic [PROG_W-1:0] e;
        e = model_prog();
        n_cmp++;
        if (prog !== e) begin
            n_bad++;
            for (int i = 0; i < NW; i++) begin
                if (prog[PROG_W-1-WORD_W*i -: WORD_W] !== e[PROG_W-1-WORD_W*i -: WORD_W]) begin
                    $display("FAIL %s: prog word %0d got %0h expected %0h", name, i,
                             prog[PROG_W-1-WORD_W*i -: WORD_W], e[PROG_W-1-WORD_W*i -: WORD_W]);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clb_clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] w);
        int budget;
        bit rdy;
        bit ok;
        budget = 20;
        ok = 0;
        s_data  = w;
        s_valid = 1;
        while (budget > 0) begin
            rdy = s_ready;
            tick();
            budget--;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        s_valid = 0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no s_ready expected s_ready within 20 cycles");
        end
    endtask

    task automatic run_frame(input int pat, input bit flip, input int gap_pct,
                             input int abort_at, input bit junk);
        logic [31:0] w;
        logic [31:0] x;
        x = '0;
        if (junk) begin
            send(32'h0);
            send(32'hFFFF_FFFF);
            chk("junk_busy", busy, 0);
            chk("junk_done", cfg_done, m_done);
        end
        send(SYNC);
        m_done = 0;
        m_err  = 0;
        m_cnt  = 0;
        chk("sync_busy", busy, 1);
        chk("sync_cnt", word_cnt, 0);
        chk("sync_done", cfg_done, 0);
        for (int i = 0; i <= NW; i++) begin
            if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(3)) + 1);
            if (i == abort_at) begin
                s_valid = 1;
                s_data  = $urandom;
                abort   = 1;
                tick();
                s_valid = 0;
                abort   = 0;
                m_done  = 0;
                m_err   = 1;
                chk("abort_busy", busy, 0);
                chk("abort_cnt", word_cnt, m_cnt);
                chk("abort_done", cfg_done, m_done);
                chk("abort_err", cfg_err, m_err);
                chk("abort_ready", s_ready, 1);
                chk_prog("abort_prog");
                return;
            end
            if (i < NW) begin
                w = (pat == 1) ? $urandom : 32'(i);
                if (pat == 2 && i == 5) w = SYNC;
                send(w);
                hist.push_back(w);
                void'(hist.pop_front());
                m_cnt++;
                x ^= w;
            end else begin
                chk("pre_chk_cnt", word_cnt, NW);
                chk("pre_chk_busy", busy, 1);
                chk("pre_chk_done", cfg_done, 0);
                send(x ^ {31'b0, flip});
                m_done = !flip;
                m_err  = flip;
                chk("commit_ready", s_ready, 0);
                chk("commit_busy", busy, 0);
                chk("commit_done", cfg_done, m_done);
                chk("commit_err", cfg_err, m_err);
                chk("commit_cnt", word_cnt, m_cnt);
                chk_prog("commit_prog");
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{0, 0,  0, -1, 0, 1, 0, NW};
        tbl[1] = '{0, 1,  0, -1, 0, 0, 1, NW};
        tbl[2] = '{0, 0, 40, -1, 0, 1, 0, NW};
        tbl[3] = '{0, 0,  0, -1, 1, 1, 0, NW};
        tbl[4] = '{0, 0,  0, 50, 0, 0, 1, 50};
        tbl[5] = '{2, 0, 20, -1, 0, 1, 0, NW};
        tbl[6] = '{1, 0, 30, NW, 0, 0, 1, NW};
        tbl[7] = '{1, 0, 10, -1, 1, 1, 0, NW};

        rst = 1; s_valid = 0; abort = 0; s_data = '0;
        model_reset();
        #12;
        chk("rst_prog_zero", {63'b0, prog == '0}, 1);
        chk("rst_ready", s_ready, 1);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", word_cnt, 0);
        rst = 0;
        tick();

        for (int v = 0; v < 8; v++) begin
            run_frame(tbl[v].pat, tbl[v].flip, tbl[v].gap_pct, tbl[v].abort_at, tbl[v].junk);
            chk($sformatf("vec%0d_done", v), cfg_done, tbl[v].exp_done);
            chk($sformatf("vec%0d_err", v), cfg_err, tbl[v].exp_err);
            chk($sformatf("vec%0d_cnt", v), word_cnt, tbl[v].exp_cnt);
            if (v == 0) begin
                chk("good_first_word", prog[PROG_W-1 -: 32], 0);
                chk("good_last_word", prog[31:0], 137);
            end
        end

        // last table frame ends in COMMIT with a verified frame; abort there and in IDLE is ignored
        abort = 1;
        tick();
        chk("abort_commit_done", cfg_done, 1);
        chk("abort_commit_err", cfg_err, 0);
        chk("abort_commit_ready", s_ready, 1);
        tick();
        abort = 0;
        chk("abort_idle_done", cfg_done, 1);
        chk("abort_idle_busy", busy, 0);
        chk_prog("abort_idle_prog");

        for (int r = 0; r < 5; r++) begin
            run_frame(1, bit'($urandom_range(1)), int'($urandom_range(50)),
                      ($urandom_range(3) == 0) ? int'($urandom_range(NW)) : -1,
                      bit'($urandom_range(1)));
        end

        send(SYNC);
        for (int i = 0; i < 20; i++) send($urandom);
        #2;
        rst = 1;
        #1;
        model_reset();
        chk("midrst_prog_zero", {63'b0, prog == '0}, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", word_cnt, 0);
        chk("midrst_done", cfg_done, 0);
        chk("midrst_err", cfg_err, 0);
        chk("midrst_ready", s_ready, 1);
        @(negedge clb_clk);
        rst = 0;
        tick();
        run_frame(0, 0, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
